fpu_lng_sched: RTL and testbench
================================

FPU_LNG_SCHED -- requirements
Module: fpu_lng_sched

Interface
REQ-001 SHALL have parameter LAT_S, default 12: single-precision occupancy of the shared long-latency unit (div/sqrt), in cycles, range 2..63.
REQ-002 SHALL have parameter LAT_D, default 20: double-precision occupancy, in cycles, range 2..63.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_en, input, 3 bits: request valid per FP port; bit0=u1, bit1=u3, bit2=u5.
REQ-006 SHALL have port req_dbl, input, 3 bits: per-port double-precision flag.
REQ-007 SHALL have port req_tag, input, 42 bits: per-port 14-bit retire tag; port n occupies bits [14n+13:14n].
REQ-008 SHALL have port flush, input, 1 bit: pipeline kill; present only with FPU_LNG_FLUSH_EN.
REQ-009 SHALL have port gnt, output, 3 bits: one-hot grant, combinational.
REQ-010 SHALL have port unit_start, output, 1 bit: start pulse to the shared unit.
REQ-011 SHALL have port unit_dbl, output, 1 bit: precision of the started op.
REQ-012 SHALL have port unit_sel, output, 2 bits: index of the port that owns the unit.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port ret_en, output, 3 bits: registered per-port retire pulse.
REQ-015 SHALL have port ret, output, 42 bits: registered per-port retire tag, same packing as req_tag.

Function
REQ-016 SHALL implement states IDLE, BUSY and DONE.
REQ-017 SHALL, in IDLE with any req_en bit set, grant the first requesting port at or after the round-robin pointer, in order u1, u3, u5, wrapping to u1.
REQ-018 SHALL assert gnt, unit_start and unit_dbl in the grant cycle; the requester holds req_en until granted.
REQ-019 SHALL, on grant: latch the tag and unit_sel; load cnt=(req_dbl ? LAT_D : LAT_S)-1; set pointer to the granted index+1 mod 3; go to BUSY.
REQ-020 SHALL decrement cnt each BUSY cycle, and go to DONE on the cycle when cnt==0.
REQ-021 SHALL, on entry to DONE: drive ret_en[unit_sel]=1 and that port's ret field to the latched tag for exactly one cycle, then return to IDLE.
REQ-022 SHALL drive all other ret fields, and all ret fields outside DONE, to zero; ret is OR-combined with other result sources.
REQ-023 SHALL NOT grant in BUSY or DONE; gnt and unit_start are 0 there.
REQ-024 SHALL give back-to-back requests from different ports a grant-to-grant spacing of LAT+2 cycles.
REQ-025 SHALL leave the pointer unchanged while no grant occurs.

Reset
REQ-026 SHALL, while rst is high: set state=IDLE, pointer=0 (u1 first), cnt=0, latched tag=0, unit_sel=0; hold gnt, unit_start, ret_en and ret at 0.
REQ-027 SHALL, on rst asserted in BUSY or DONE: abandon the operation with no ret_en; rst dominates every other input in the same cycle.

Configuration
REQ-028 SHALL, with FPU_LNG_FLUSH_EN defined: add the flush port; flush in IDLE suppresses gnt and unit_start; flush in BUSY returns to IDLE with no ret_en; flush in the DONE-entry cycle suppresses ret_en; the pointer is preserved in all cases.
REQ-029 SHALL, without FPU_LNG_FLUSH_EN: omit the flush port; every started operation retires exactly once.

Structure
REQ-030 SHALL place the state enum (IDLE/BUSY/DONE), the tag width constant 14 and the port-index constants in the shared FP package, next to the fop_* opcode definitions.
REQ-031 SHALL implement the 3-way round-robin picker as one sub-module, fpu_rr3_pick, with inputs req[2:0] and ptr[1:0] and output one-hot gnt[2:0].
REQ-032 SHALL keep the rest flat: state register, cnt, tag latch and ret registers.

Verification
REQ-033 SHALL cover: rst released, req_en=001, req_dbl=0, tag 0x0123 -> gnt=001 same cycle; ret_en=001 and ret[13:0]=0x0123 exactly 13 cycles later (LAT_S+1).
REQ-034 SHALL cover: req_en=111 held continuously, all single precision -> grant order u1, u3, u5, u1, with successive grants 14 cycles apart.
REQ-035 SHALL cover: grant to u5 with req_dbl=1 -> busy=1 for 21 cycles; the next grant goes to u1 when u1 and u3 both request.
REQ-036 SHALL cover, with FPU_LNG_FLUSH_EN: flush on cycle 5 of BUSY -> no ret_en; IDLE next cycle; a new request is granted the cycle after.
REQ-037 SHALL cover: rst asserted in the cycle before DONE -> ret_en stays 000; pointer=0; the next grant goes to u1.
REQ-038 SHALL cover: LAT_S=2, one request -> ret_en exactly 3 cycles after grant; IDLE after 4 cycles.

Source files
------------

// File: rtl/fpu_lng_sched_pkg.sv
// Shared FP package: opcodes, long-latency scheduler state and port indices.
package fpu_lng_sched_pkg;

  typedef enum logic [3:0] {
    FOP_ADD  = 4'd0,
    FOP_SUB  = 4'd1,
    FOP_MUL  = 4'd2,
    FOP_FMA  = 4'd3,
    FOP_DIV  = 4'd4,
    FOP_SQRT = 4'd5,
    FOP_CVT  = 4'd6,
    FOP_CMP  = 4'd7
  } fop_e;

  typedef enum logic [1:0] {
    LNG_IDLE = 2'd0,
    LNG_BUSY = 2'd1,
    LNG_DONE = 2'd2
  } lng_state_e;

  localparam int unsigned FP_TAG_W  = 14;
  localparam int unsigned FP_NPORT  = 3;
  localparam int unsigned LNG_CNT_W = 6;

  localparam logic [1:0] FP_PORT_U1 = 2'd0;
  localparam logic [1:0] FP_PORT_U3 = 2'd1;
  localparam logic [1:0] FP_PORT_U5 = 2'd2;

endpackage

// File: rtl/fpu_lng_sched_rr3_pick.sv
// 3-way round-robin picker: first requester at or after ptr, order u1, u3, u5.
module fpu_rr3_pick
  import fpu_lng_sched_pkg::*;
(
  input  logic [FP_NPORT-1:0] req,
  input  logic [1:0]          ptr,
  output logic [FP_NPORT-1:0] gnt
);

  // Priority chain rotated by the pointer; an out-of-range pointer acts as u1.
  always_comb begin
    gnt = '0;
    case (ptr)
      FP_PORT_U3: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      FP_PORT_U5: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/fpu_lng_sched.sv
// Scheduler for the shared long-latency FP unit (div/sqrt) across ports u1/u3/u5.
// Optional pipeline-kill port enabled by defining FPU_LNG_FLUSH_EN.
module fpu_lng_sched
  import fpu_lng_sched_pkg::*;
#(
  parameter int unsigned LAT_S = 12,
  parameter int unsigned LAT_D = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_en,
  input  logic [2:0]  req_dbl,
  input  logic [41:0] req_tag,
`ifdef FPU_LNG_FLUSH_EN
  input  logic        flush,
`endif
  output logic [2:0]  gnt,
  output logic        unit_start,
  output logic        unit_dbl,
  output logic [1:0]  unit_sel,
  output logic        busy,
  output logic [2:0]  ret_en,
  output logic [41:0] ret
);

  lng_state_e                state_q, state_d;
  logic [1:0]                ptr_q, ptr_d;
  logic [LNG_CNT_W-1:0]      cnt_q, cnt_d;
  logic [FP_TAG_W-1:0]       tag_q, tag_d;
  logic [1:0]                sel_q, sel_d;
  logic [FP_NPORT-1:0]       ret_en_q, ret_en_d;
  logic [FP_NPORT*FP_TAG_W-1:0] ret_q, ret_d;

  logic                      flush_w;
  logic [FP_NPORT-1:0]       pick_gnt;
  logic [1:0]                gidx;
  logic [FP_TAG_W-1:0]       gtag;

`ifdef FPU_LNG_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  fpu_rr3_pick u_pick (
    .req (req_en),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LNG_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one op in flight; flush abandons it, cnt==0 ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LNG_IDLE: if (|gnt) state_d = LNG_BUSY;
      LNG_BUSY: begin
        if (flush_w)                    state_d = LNG_IDLE;
        else if (cnt_q == '0)           state_d = LNG_DONE;
      end
      LNG_DONE: state_d = LNG_IDLE;
      default:  state_d = LNG_IDLE;
    endcase
  end

  // Grant-cycle outputs: only in IDLE, never under reset or flush.
  always_comb begin
    gnt        = '0;
    unit_start = 1'b0;
    unit_dbl   = 1'b0;
    if (state_q == LNG_IDLE && !rst && !flush_w) begin
      gnt        = pick_gnt;
      unit_start = |pick_gnt;
      unit_dbl   = |(pick_gnt & req_dbl);
    end
  end

  // Decode granted port index and its tag.
  always_comb begin
    gidx = FP_PORT_U1;
    if (pick_gnt[1])      gidx = FP_PORT_U3;
    else if (pick_gnt[2]) gidx = FP_PORT_U5;
    case (gidx)
      FP_PORT_U3: gtag = req_tag[FP_TAG_W +: FP_TAG_W];
      FP_PORT_U5: gtag = req_tag[2*FP_TAG_W +: FP_TAG_W];
      default:    gtag = req_tag[0 +: FP_TAG_W];
    endcase
  end

  // Datapath next values: latch on grant, count down in BUSY, retire on DONE entry.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    sel_d    = sel_q;
    ret_en_d = '0;
    ret_d    = '0;
    if (|gnt) begin
      ptr_d = (gidx == FP_PORT_U5) ? FP_PORT_U1 : gidx + 2'd1;
      cnt_d = req_dbl[gidx] ? LNG_CNT_W'(LAT_D - 1) : LNG_CNT_W'(LAT_S - 1);
      tag_d = gtag;
      sel_d = gidx;
    end else if (state_q == LNG_BUSY && cnt_q != '0) begin
      cnt_d = cnt_q - LNG_CNT_W'(1);
    end
    if (state_q == LNG_BUSY && cnt_q == '0 && !flush_w) begin
      case (sel_q)
        FP_PORT_U3: begin
          ret_en_d[1]                  = 1'b1;
          ret_d[FP_TAG_W +: FP_TAG_W]  = tag_q;
        end
        FP_PORT_U5: begin
          ret_en_d[2]                   = 1'b1;
          ret_d[2*FP_TAG_W +: FP_TAG_W] = tag_q;
        end
        default: begin
          ret_en_d[0]           = 1'b1;
          ret_d[0 +: FP_TAG_W]  = tag_q;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= FP_PORT_U1;
      cnt_q    <= '0;
      tag_q    <= '0;
      sel_q    <= FP_PORT_U1;
      ret_en_q <= '0;
      ret_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      sel_q    <= sel_d;
      ret_en_q <= ret_en_d;
      ret_q    <= ret_d;
    end
  end

  // Retire outputs are forced quiet while reset is held so a DONE cycle is abandoned.
  always_comb begin
    unit_sel = sel_q;
    busy     = (state_q != LNG_IDLE);
    ret_en   = rst ? '0 : ret_en_q;
    ret      = rst ? '0 : ret_q;
  end

endmodule

// File: tb/tb_fpu_lng_sched.sv
// Bench for fpu_lng_sched: time-based reference model checked every cycle,
// plus directed scenarios with literal expectations. FPU_LNG_FLUSH_EN adds flush cases.
module tb_fpu_lng_sched;

  localparam int LAT_S = 12;
  localparam int LAT_D = 20;
  localparam int TW    = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  req_en = '0, req_dbl = '0;
  logic [41:0] req_tag = '0;
  logic        flush_tb = 1'b0;
  logic [2:0]  gnt, ret_en;
  logic        unit_start, unit_dbl, busy;
  logic [1:0]  unit_sel;
  logic [41:0] ret;

  logic [2:0]  b_req_en = '0, b_req_dbl = '0;
  logic [41:0] b_req_tag = '0;
  logic [2:0]  b_gnt, b_ret_en;
  logic        b_unit_start, b_unit_dbl, b_busy;
  logic [1:0]  b_unit_sel;
  logic [41:0] b_ret;

  fpu_lng_sched #(.LAT_S(LAT_S), .LAT_D(LAT_D)) u_dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_dbl(req_dbl), .req_tag(req_tag),
`ifdef FPU_LNG_FLUSH_EN
    .flush(flush_tb),
`endif
    .gnt(gnt), .unit_start(unit_start), .unit_dbl(unit_dbl), .unit_sel(unit_sel),
    .busy(busy), .ret_en(ret_en), .ret(ret)
  );

  fpu_lng_sched #(.LAT_S(2), .LAT_D(LAT_D)) u_dut_s2 (
    .clk(clk), .rst(rst), .req_en(b_req_en), .req_dbl(b_req_dbl), .req_tag(b_req_tag),
`ifdef FPU_LNG_FLUSH_EN
    .flush(1'b0),
`endif
    .gnt(b_gnt), .unit_start(b_unit_start), .unit_dbl(b_unit_dbl), .unit_sel(b_unit_sel),
    .busy(b_busy), .ret_en(b_ret_en), .ret(b_ret)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the unit is free from cycle free_at; an op granted at
  // cycle g retires at g+LAT+1 and frees the unit at g+LAT+2.
  longint      m_cyc = 0, free_at = 0, pend_at = 0;
  int          m_ptr = 0, pend_port = 0;
  bit          pend = 1'b0, m_valid = 1'b0;
  logic [1:0]  m_sel = '0;
  logic [13:0] pend_tag = '0;

  always @(negedge clk) begin : model
    logic [2:0]  e_gnt, e_ret_en;
    logic [41:0] e_ret;
    logic        e_dbl, e_busy;
    logic [1:0]  e_sel;
    int          idx;
    e_gnt = '0; e_ret_en = '0; e_ret = '0; e_dbl = 1'b0;
    e_busy = (m_cyc < free_at);
    e_sel = m_sel;
    if (rst) begin
      chk("m_rst_gnt", 64'(gnt), 64'(0));
      chk("m_rst_start", 64'(unit_start), 64'(0));
      chk("m_rst_ret_en", 64'(ret_en), 64'(0));
      chk("m_rst_ret", 64'(ret), 64'(0));
      if (m_valid) begin
        chk("m_rst_busy", 64'(busy), 64'(e_busy));
        chk("m_rst_sel", 64'(unit_sel), 64'(e_sel));
      end
      free_at = m_cyc + 1; m_ptr = 0; m_sel = '0; pend = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (pend && m_cyc == pend_at) begin
        e_ret_en[pend_port] = 1'b1;
        e_ret[pend_port*TW +: TW] = pend_tag;
        pend = 1'b0;
      end
      if (flush_tb && pend) begin
        pend = 1'b0;
        free_at = m_cyc + 1;
      end
      if (!e_busy && !flush_tb && req_en != 3'b000) begin
        idx = -1;
        for (int k = 0; k < 3; k++)
          if (idx < 0 && req_en[(m_ptr + k) % 3]) idx = (m_ptr + k) % 3;
        e_gnt[idx] = 1'b1;
        e_dbl = req_dbl[idx];
        pend = 1'b1; pend_port = idx; pend_tag = req_tag[idx*TW +: TW];
        pend_at = m_cyc + (e_dbl ? LAT_D : LAT_S) + 1;
        free_at = pend_at + 1;
        m_sel = 2'(idx);
        m_ptr = (idx + 1) % 3;
      end
      chk("m_gnt", 64'(gnt), 64'(e_gnt));
      chk("m_start", 64'(unit_start), 64'(|e_gnt));
      chk("m_dbl", 64'(unit_dbl), 64'(e_dbl));
      chk("m_busy", 64'(busy), 64'(e_busy));
      chk("m_sel", 64'(unit_sel), 64'(e_sel));
      chk("m_ret_en", 64'(ret_en), 64'(e_ret_en));
      chk("m_ret", 64'(ret), 64'(e_ret));
    end
    m_cyc++;
  end

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic wait_gnt(input int budget, output logic [2:0] g, output int at);
    g = '0; at = -1;
    for (int i = 0; i < budget; i++) begin
      smp();
      if (gnt != 3'b000) begin
        g = gnt; at = cyc_cnt;
        break;
      end
      adv();
    end
    if (g == 3'b000) begin
      n_tests++; n_fail++;
      $display("FAIL wait_gnt: no grant within %0d cycles", budget);
    end
  endtask

  logic [2:0] g;
  int         at, c0, prev_at, nb;
  logic [2:0] acc;
  logic [41:0] rv;
  logic [2:0] order [4];

  initial begin
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    adv(); adv(); adv();
    rst = 1'b0;

    // Single u1 op: same-cycle grant, retire LAT_S+1 later.
    req_en = 3'b001; req_dbl = 3'b000; req_tag = 42'h0123;
    c0 = cyc_cnt;
    wait_gnt(5, g, at);
    chk("t1_gnt", 64'(g), 64'(3'b001));
    chk("t1_gnt_cycle", 64'(at - c0), 64'(0));
    adv(); req_en = '0;
    repeat (12) adv();
    smp();
    rv = ret;
    chk("t1_ret_en", 64'(ret_en), 64'(3'b001));
    chk("t1_ret_tag", 64'(rv[13:0]), 64'(14'h0123));

    // LAT_S=2 instance: retire 3 cycles after grant, idle at 4.
    adv();
    b_req_en = 3'b010; b_req_tag = 42'h0ABC << 14;
    smp();
    chk("s2_gnt", 64'(b_gnt), 64'(3'b010));
    adv(); b_req_en = '0;
    smp(); chk("s2_ret_en_1", 64'(b_ret_en), 64'(0));
    adv(); smp(); chk("s2_ret_en_2", 64'(b_ret_en), 64'(0));
    adv(); smp();
    rv = b_ret;
    chk("s2_ret_en_3", 64'(b_ret_en), 64'(3'b010));
    chk("s2_ret_tag", 64'(rv[27:14]), 64'(14'h0ABC));
    chk("s2_busy_3", 64'(b_busy), 64'(1));
    adv(); smp(); chk("s2_busy_4", 64'(b_busy), 64'(0));

    // All ports requesting: u1, u3, u5, u1 at 14-cycle spacing.
    adv(); rst = 1'b1;
    adv(); rst = 1'b0;
    req_en = 3'b111; req_dbl = 3'b000;
    req_tag = {14'h3FFF, 14'h2AAA, 14'h1111};
    prev_at = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(20, g, at);
      chk($sformatf("t2_order_%0d", i), 64'(g), 64'(order[i]));
      if (i > 0) chk($sformatf("t2_space_%0d", i), 64'(at - prev_at), 64'(LAT_S + 2));
      prev_at = at;
    end
    adv(); req_en = '0;

    // Double-precision u5: busy 21 cycles, then u1 wins over u3.
    req_en = 3'b100; req_dbl = 3'b100; req_tag = {14'h2D5A, 28'h0};
    wait_gnt(30, g, at);
    chk("t3_gnt_u5", 64'(g), 64'(3'b100));
    adv(); req_en = 3'b011; req_dbl = 3'b000; req_tag = {14'h0, 14'h0B0B, 14'h0A0A};
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!busy) break;
      nb++;
      adv();
    end
    chk("t3_busy_cycles", 64'(nb), 64'(LAT_D + 1));
    chk("t3_next_gnt", 64'(gnt), 64'(3'b001));
    adv(); req_en = '0;

    // Reset in the cycle before DONE: no retire, pointer back to u1.
    req_en = 3'b010; req_tag = {14'h0, 14'h1357, 14'h0};
    wait_gnt(30, g, at);
    chk("t4_gnt_u3", 64'(g), 64'(3'b010));
    adv(); req_en = '0;
    repeat (10) adv();
    adv(); rst = 1'b1;
    smp(); acc = ret_en;
    adv(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp(); acc = acc | ret_en;
      adv();
    end
    chk("t4_no_ret", 64'(acc), 64'(0));
    req_en = 3'b111; req_tag = {14'h0333, 14'h0222, 14'h0111};
    wait_gnt(5, g, at);
    chk("t4_gnt_u1", 64'(g), 64'(3'b001));
    adv(); req_en = '0;

`ifdef FPU_LNG_FLUSH_EN
    // Flush on BUSY cycle 5: idle next cycle, new request granted there.
    req_en = 3'b001; req_tag = 42'h0777;
    wait_gnt(30, g, at);
    chk("t5_gnt_u1", 64'(g), 64'(3'b001));
    adv(); req_en = '0;
    repeat (3) adv();
    adv(); flush_tb = 1'b1;
    smp(); chk("t5_busy_flush", 64'(busy), 64'(1));
    adv(); flush_tb = 1'b0; req_en = 3'b111;
    smp();
    chk("t5_idle", 64'(busy), 64'(0));
    chk("t5_gnt_u3", 64'(gnt), 64'(3'b010));
    adv(); req_en = '0;
    repeat (6) adv();
    smp(); chk("t5_no_ret", 64'(ret_en), 64'(0));
    repeat (10) adv();
    req_en = 3'b001; flush_tb = 1'b1;
    smp(); chk("t5_idle_flush_gnt", 64'(gnt), 64'(0));
    adv(); flush_tb = 1'b0;
    smp(); chk("t5_after_flush_gnt", 64'(gnt), 64'(3'b001));
    adv(); req_en = '0;
`endif

    repeat (30) adv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
